// File: rtl/musk_fetch_unit_pkg.sv
// MUSKBUS request/response definitions shared by the Musk instruction-fetch front end.
package musk_fetch_unit_pkg;

    localparam int unsigned BUS_DATA_W     = 64;
    localparam int unsigned BUS_LINE_BYTES = 64;
    localparam int unsigned BEAT_BYTES     = BUS_DATA_W / 8;
    localparam int unsigned BEATS_PER_LINE = BUS_LINE_BYTES / BEAT_BYTES;

    // MUSKBUS tag fields: {opcode, space, 8-bit id}
    localparam logic [1:0]  READ   = 2'd1;
    localparam logic [2:0]  MEMORY = 3'd1;
    localparam logic [12:0] REQ_TAG_READ_MEM = {READ, MEMORY, 8'h00};

    typedef struct packed {
        logic        cyc;
        logic [63:0] addr;
    } req_t;

    typedef struct packed {
        logic        cyc;
        logic [63:0] data;
    } resp_t;

endpackage

// File: rtl/musk_fetch_ringbuf.sv
// Circular byte buffer: one aligned 64-bit beat write port and a wrapped decode read window.
module musk_fetch_ringbuf
    import musk_fetch_unit_pkg::*;
#(
    parameter int unsigned BUF_BYTES = 128,
    parameter int unsigned WIN_BYTES = 15,
    localparam int unsigned IdxW = $clog2(BUF_BYTES)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [IdxW-1:0]        wr_idx,
    input  logic [BUS_DATA_W-1:0]  wr_data,
    input  logic [IdxW-1:0]        rd_idx,
    output logic [8*WIN_BYTES-1:0] window
);

    logic [7:0] mem [BUF_BYTES];

    // Beats are always written at an 8-byte aligned index, so they never straddle the wrap.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < int'(BEAT_BYTES); k++) begin
                mem[IdxW'(wr_idx + IdxW'(k))] <= wr_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        window = '0;
        for (int i = 0; i < int'(WIN_BYTES); i++) begin
            window[8*i +: 8] = mem[IdxW'(rd_idx + IdxW'(i))];
        end
    end

endmodule

// File: rtl/musk_fetch_unit.sv
// Musk fetch front end: MUSKBUS line-fetch FSM feeding a circular decode buffer.
// Optional perf counters with a final-block report: define MUSK_FETCH_PERF_EN.
module musk_fetch_unit
    import musk_fetch_unit_pkg::*;
#(
    parameter int unsigned BUF_BYTES  = 128,
    parameter int unsigned LINE_BYTES = BUS_LINE_BYTES,
    parameter int unsigned WIN_BYTES  = 15,
    localparam int unsigned PtrW = $clog2(BUF_BYTES) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [63:0]            entry,
    output logic                   bus_reqcyc,
    output logic [63:0]            bus_req,
    output logic [12:0]            bus_reqtag,
    input  logic                   bus_reqack,
    input  logic                   bus_respcyc,
    input  logic [63:0]            bus_resp,
    output logic                   bus_respack,
    input  logic                   redirect_valid,
    input  logic [63:0]            redirect_rip,
    output logic [8*WIN_BYTES-1:0] dec_bytes,
    output logic [PtrW-1:0]        dec_avail,
    input  logic [3:0]             dec_consume,
    output logic                   fetch_idle
);

    localparam int unsigned IdxW  = PtrW - 1;
    localparam int unsigned OffW  = $clog2(LINE_BYTES);
    localparam int unsigned Beats = LINE_BYTES / BEAT_BYTES;
    localparam int unsigned BeatW = $clog2(Beats);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDrain} state_e;

    state_e          state_q, state_d;
    req_t            req_q, req_d;
    resp_t           resp;
    logic [63:0]     line_q, line_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic            flush_q, flush_d;
    logic            buf_we;
    logic [PtrW-1:0] live_raw;
    logic            live_neg;
    logic            can_req;
    logic            last_beat;
    logic [63:0]     redirect_line;
    logic [PtrW-1:0] consume_max;

    assign resp          = '{cyc: bus_respcyc, data: bus_resp};
    assign live_raw      = wr_ptr_q - rd_ptr_q;
    // A wrapped difference above BUF_BYTES can only be a negative live count
    // (first line after a restart still below the skip offset).
    assign live_neg      = live_raw > PtrW'(BUF_BYTES);
    assign can_req       = live_neg || (live_raw <= PtrW'(BUF_BYTES - LINE_BYTES));
    assign last_beat     = beat_q == BeatW'(Beats - 1);
    assign redirect_line = {redirect_rip[63:OffW], {OffW{1'b0}}};

    assign bus_reqcyc  = req_q.cyc;
    assign bus_req     = req_q.addr;
    assign bus_reqtag  = REQ_TAG_READ_MEM;
    assign bus_respack = resp.cyc && (state_q == StResp || state_q == StDrain);
    assign dec_avail   = live_neg ? '0 : live_raw;
    assign fetch_idle  = state_q == StIdle;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        line_d   = line_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q + PtrW'(dec_consume);
        beat_d   = beat_q;
        flush_d  = flush_q;
        buf_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!redirect_valid && can_req) begin
                    state_d    = StReq;
                    req_d.cyc  = 1'b1;
                    req_d.addr = line_q;
                end
            end
            StReq: begin
                // The request must stay up until acked even if a redirect arrives.
                if (bus_reqack) begin
                    state_d   = (flush_q || redirect_valid) ? StDrain : StResp;
                    req_d.cyc = 1'b0;
                    beat_d    = '0;
                    flush_d   = 1'b0;
                end else if (redirect_valid) begin
                    flush_d = 1'b1;
                end
            end
            StResp: begin
                if (resp.cyc) begin
                    beat_d = beat_q + BeatW'(1);
                    if (redirect_valid) begin
                        state_d = last_beat ? StIdle : StDrain;
                    end else begin
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrW'(BEAT_BYTES);
                        if (last_beat) begin
                            line_d  = line_q + 64'(LINE_BYTES);
                            state_d = StIdle;
                        end
                    end
                end else if (redirect_valid) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (resp.cyc) begin
                    beat_d = beat_q + BeatW'(1);
                    if (last_beat) begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = PtrW'(redirect_rip[OffW-1:0]);
            line_d   = redirect_line;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            req_q    <= '0;
            line_q   <= {entry[63:OffW], {OffW{1'b0}}};
            wr_ptr_q <= '0;
            rd_ptr_q <= PtrW'(entry[OffW-1:0]);
            beat_q   <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            line_q   <= line_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            beat_q   <= beat_d;
            flush_q  <= flush_d;
        end
    end

    musk_fetch_ringbuf #(
        .BUF_BYTES(BUF_BYTES),
        .WIN_BYTES(WIN_BYTES)
    ) u_ringbuf (
        .clk    (clk),
        .wr_en  (buf_we),
        .wr_idx (wr_ptr_q[IdxW-1:0]),
        .wr_data(resp.data),
        .rd_idx (rd_ptr_q[IdxW-1:0]),
        .window (dec_bytes)
    );

    assign consume_max = (dec_avail < PtrW'(WIN_BYTES)) ? dec_avail : PtrW'(WIN_BYTES);

    consume_legal: assert property (@(posedge clk) disable iff (!reset)
        PtrW'(dec_consume) <= consume_max)
        else $fatal(1, "dec_consume exceeds available window");

`ifdef MUSK_FETCH_PERF_EN
    logic [31:0] perf_lines_q, perf_drained_q, perf_redirects_q, perf_starved_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_lines_q     <= '0;
            perf_drained_q   <= '0;
            perf_redirects_q <= '0;
            perf_starved_q   <= '0;
        end else begin
            if (buf_we && last_beat) perf_lines_q <= perf_lines_q + 32'd1;
            if (resp.cyc && (state_q == StDrain || (state_q == StResp && redirect_valid))) begin
                perf_drained_q <= perf_drained_q + 32'd1;
            end
            if (redirect_valid) perf_redirects_q <= perf_redirects_q + 32'd1;
            if (dec_avail < PtrW'(WIN_BYTES)) perf_starved_q <= perf_starved_q + 32'd1;
        end
    end

    final begin
        $display("musk_fetch_unit perf: lines=%0d drained=%0d redirects=%0d starved=%0d",
                 perf_lines_q, perf_drained_q, perf_redirects_q, perf_starved_q);
    end
`endif

endmodule

// File: tb/tb_musk_fetch_unit.sv
// Scoreboarded bench for musk_fetch_unit: directed fetch, stall, redirect and reset scenarios.
module tb_musk_fetch_unit;
    import musk_fetch_unit_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  entry;
    logic         bus_reqcyc;
    logic [63:0]  bus_req;
    logic [12:0]  bus_reqtag;
    logic         bus_reqack;
    logic         bus_respcyc;
    logic [63:0]  bus_resp;
    logic         bus_respack;
    logic         redirect_valid;
    logic [63:0]  redirect_rip;
    logic [119:0] dec_bytes;
    logic [7:0]   dec_avail;
    logic [3:0]   dec_consume;
    logic         fetch_idle;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    musk_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .entry         (entry),
        .bus_reqcyc    (bus_reqcyc),
        .bus_req       (bus_req),
        .bus_reqtag    (bus_reqtag),
        .bus_reqack    (bus_reqack),
        .bus_respcyc   (bus_respcyc),
        .bus_resp      (bus_resp),
        .bus_respack   (bus_respack),
        .redirect_valid(redirect_valid),
        .redirect_rip  (redirect_rip),
        .dec_bytes     (dec_bytes),
        .dec_avail     (dec_avail),
        .dec_consume   (dec_consume),
        .fetch_idle    (fetch_idle)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [7:0] win_byte(input int i);
        return dec_bytes[8*i +: 8];
    endfunction

    // Byte at line offset k carries (line address + k) mod 256.
    function automatic logic [63:0] beat_data(input logic [63:0] line, input int beat);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = line[7:0] + 8'(8*beat + k);
        return d;
    endfunction

    // Monitor: every accepted request is matched against the scoreboard queue.
    always begin
        @(negedge clk);
        #2;
        if (reset === 1'b1 && bus_reqcyc === 1'b1 && bus_reqack === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_req: got 0x%0h, none expected", bus_req);
            end else begin
                mon_exp = sb_q.pop_front();
                check("sb_req_addr", bus_req, mon_exp);
                check("sb_req_tag", 64'(bus_reqtag), 64'({READ, MEMORY, 8'h00}));
            end
        end
    end

    task automatic apply_reset(input logic [63:0] e);
        reset          = 1'b0;
        entry          = e;
        bus_reqack     = 1'b0;
        bus_respcyc    = 1'b0;
        bus_resp       = '0;
        redirect_valid = 1'b0;
        redirect_rip   = '0;
        dec_consume    = '0;
        sb_q.delete();
        step();
        step();
        check("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        check("rst_req", bus_req, 64'd0);
        check("rst_respack", 64'(bus_respack), 64'd0);
        check("rst_avail", 64'(dec_avail), 64'd0);
        check("rst_idle", 64'(fetch_idle), 64'd1);
        reset = 1'b1;
    endtask

    task automatic wait_req();
        int i = 0;
        while (bus_reqcyc !== 1'b1 && i < 40) begin
            step();
            i++;
        end
        if (bus_reqcyc !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: got reqcyc=%0b expected 1 within 40 cycles", bus_reqcyc);
        end
    endtask

    // Serve one request: optional ack delay with a redirect inside it, then 8 beats with an
    // optional redirect on one beat.
    task automatic serve_line(input int ack_wait, input int redir_wait, input int redir_beat,
                              input logic [63:0] rip);
        logic [63:0] a;
        wait_req();
        if (bus_reqcyc !== 1'b1) return;
        a = bus_req;
        for (int i = 0; i < ack_wait; i++) begin
            redirect_valid = (i == redir_wait);
            redirect_rip   = rip;
            step();
            check("req_hold_cyc", 64'(bus_reqcyc), 64'd1);
            check("req_hold_addr", bus_req, a);
        end
        redirect_valid = 1'b0;
        bus_reqack     = 1'b1;
        step();
        bus_reqack = 1'b0;
        for (int b = 0; b < 8; b++) begin
            bus_respcyc    = 1'b1;
            bus_resp       = beat_data(a, b);
            redirect_valid = (b == redir_beat);
            redirect_rip   = rip;
            #1;
            check("respack", 64'(bus_respack), 64'd1);
            step();
        end
        bus_respcyc    = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int reqs;

        // Aligned entry, one line.
        apply_reset(64'h1000);
        sb_q.push_back(64'h1000);
        serve_line(0, -1, -1, 64'h0);
        check("t1_avail", 64'(dec_avail), 64'd64);
        check("t1_b0", 64'(win_byte(0)), 64'h00);
        check("t1_b1", 64'(win_byte(1)), 64'h01);
        check("t1_b14", 64'(win_byte(14)), 64'h0e);
        check("t1_idle", 64'(fetch_idle), 64'd1);
        step();
        check("t1_next_cyc", 64'(bus_reqcyc), 64'd1);
        check("t1_next_addr", bus_req, 64'h1040);
        check("t1_sb_empty", 64'(sb_q.size()), 64'd0);

        // Unaligned entry skips into the first line.
        apply_reset(64'h102b);
        sb_q.push_back(64'h1000);
        serve_line(0, -1, -1, 64'h0);
        check("t2_avail", 64'(dec_avail), 64'd21);
        check("t2_b0", 64'(win_byte(0)), 64'h2b);
        check("t2_b14", 64'(win_byte(14)), 64'h39);
        dec_consume = 4'd15;
        step();
        dec_consume = 4'd0;
        check("t2_avail_after", 64'(dec_avail), 64'd6);
        check("t2_b0_after", 64'(win_byte(0)), 64'h3a);

        // Stalled decoder fills the buffer, then consumption reopens fetch and wraps.
        apply_reset(64'h1000);
        sb_q.push_back(64'h1000);
        sb_q.push_back(64'h1040);
        sb_q.push_back(64'h1080);
        serve_line(0, -1, -1, 64'h0);
        serve_line(0, -1, -1, 64'h0);
        reqs = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (bus_reqcyc === 1'b1) reqs++;
        end
        check("t3_no_third_req", 64'(reqs), 64'd0);
        check("t3_full_avail", 64'(dec_avail), 64'd128);
        check("t3_full_b0", 64'(win_byte(0)), 64'h00);
        dec_consume = 4'd15;
        repeat (5) step();
        dec_consume = 4'd0;
        check("t3_avail_53", 64'(dec_avail), 64'd53);
        check("t3_b0_75", 64'(win_byte(0)), 64'h4b);
        serve_line(0, -1, -1, 64'h0);
        check("t3_avail_117", 64'(dec_avail), 64'd117);
        dec_consume = 4'd15;
        repeat (3) step();
        dec_consume = 4'd0;
        check("t3_avail_72", 64'(dec_avail), 64'd72);
        check("t3_wrap_b0", 64'(win_byte(0)), 64'h78);
        check("t3_wrap_b7", 64'(win_byte(7)), 64'h7f);
        check("t3_wrap_b8", 64'(win_byte(8)), 64'h80);
        check("t3_wrap_b14", 64'(win_byte(14)), 64'h86);
        check("t3_sb_empty", 64'(sb_q.size()), 64'd0);

        // Redirect on beat 3: remaining beats drained, refetch at the new line.
        apply_reset(64'h1000);
        sb_q.push_back(64'h1000);
        sb_q.push_back(64'h2000);
        serve_line(0, -1, 3, 64'h2005);
        check("t4_avail_zero", 64'(dec_avail), 64'd0);
        check("t4_idle", 64'(fetch_idle), 64'd1);
        serve_line(0, -1, -1, 64'h0);
        check("t4_avail", 64'(dec_avail), 64'd59);
        check("t4_b0", 64'(win_byte(0)), 64'h05);
        check("t4_b1", 64'(win_byte(1)), 64'h06);
        check("t4_sb_empty", 64'(sb_q.size()), 64'd0);

        // Slow ack with a redirect while waiting: burst drained, refetch at the new line.
        apply_reset(64'h1000);
        sb_q.push_back(64'h1000);
        sb_q.push_back(64'h3000);
        serve_line(10, 4, -1, 64'h3010);
        check("t5_avail_zero", 64'(dec_avail), 64'd0);
        serve_line(0, -1, -1, 64'h0);
        check("t5_avail", 64'(dec_avail), 64'd48);
        check("t5_b0", 64'(win_byte(0)), 64'h10);
        check("t5_sb_empty", 64'(sb_q.size()), 64'd0);

        // Asynchronous reset in the middle of a burst.
        apply_reset(64'h1000);
        sb_q.push_back(64'h1000);
        wait_req();
        bus_reqack = 1'b1;
        step();
        bus_reqack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus_respcyc = 1'b1;
            bus_resp    = beat_data(64'h1000, b);
            step();
        end
        bus_resp = beat_data(64'h1000, 3);
        #1;
        check("t6_pre_avail", 64'(dec_avail), 64'd24);
        check("t6_pre_idle", 64'(fetch_idle), 64'd0);
        check("t6_pre_respack", 64'(bus_respack), 64'd1);
        reset = 1'b0;
        entry = 64'h5047;
        #1;
        check("t6_async_respack", 64'(bus_respack), 64'd0);
        check("t6_async_avail", 64'(dec_avail), 64'd0);
        check("t6_async_idle", 64'(fetch_idle), 64'd1);
        check("t6_async_req", bus_req, 64'd0);
        check("t6_async_reqcyc", 64'(bus_reqcyc), 64'd0);
        bus_respcyc = 1'b0;
        sb_q.delete();
        sb_q.push_back(64'h5040);
        step();
        step();
        reset = 1'b1;
        serve_line(0, -1, -1, 64'h0);
        check("t6_avail", 64'(dec_avail), 64'd57);
        check("t6_b0", 64'(win_byte(0)), 64'h47);
        check("t6_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
